csr_regfile: RTL and testbench

//  Machine-mode CSR storage; slave side of the CSR port driven by the CSR functional unit.

---
 rtl/csr_regfile.sv | 142 ++++++++++++++
 tb/tb_csr_regfile.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: combinational reads, commit-time writes, counters and trap/mret updates.
// Interrupt state and the exported mtvec/mepc come straight from registers.
module csr_regfile #(
  parameter int              XLEN     = 64,
  parameter int              HART_ID  = 0,
  parameter logic [XLEN-1:0] MISA_VAL = XLEN'(64'h8000_0000_0000_1101)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            csr_rvalid_i,
  input  logic [11:0]     csr_raddr_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_rillegal_o,
  input  logic            csr_wvalid_i,
  input  logic [11:0]     csr_waddr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic [1:0]      retire_cnt_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  input  logic            msip_i,
  input  logic            mtip_i,
  input  logic            meip_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_pending_o
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  logic            status_mie, status_mpie;
  logic [2:0]      mie_q, mip_q;
  logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mcycle_q, minstret_q;
  logic [XLEN-1:0] mstatus_rd, mie_rd, mip_rd;

  // Interrupt enable/pending bits are kept packed as {MEI, MTI, MSI} and expanded on read.
  assign mstatus_rd = XLEN'({2'b11, 3'b000, status_mpie, 3'b000, status_mie, 3'b000});
  assign mie_rd     = XLEN'({mie_q[2], 3'b000, mie_q[1], 3'b000, mie_q[0], 3'b000});
  assign mip_rd     = XLEN'({mip_q[2], 3'b000, mip_q[1], 3'b000, mip_q[0], 3'b000});

  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign irq_pending_o = (|(mip_q & mie_q)) && status_mie;

  logic hit;
  always_comb begin
    csr_rdata_o = '0;
    hit         = 1'b1;
    case (csr_raddr_i)
      A_MSTATUS:                         csr_rdata_o = mstatus_rd;
      A_MISA:                            csr_rdata_o = MISA_VAL;
      A_MIE:                             csr_rdata_o = mie_rd;
      A_MTVEC:                           csr_rdata_o = mtvec_q;
      A_MSCRATCH:                        csr_rdata_o = mscratch_q;
      A_MEPC:                            csr_rdata_o = mepc_q;
      A_MCAUSE:                          csr_rdata_o = mcause_q;
      A_MTVAL:                           csr_rdata_o = mtval_q;
      A_MIP:                             csr_rdata_o = mip_rd;
      A_MCYCLE, A_CYCLE:                 csr_rdata_o = mcycle_q;
      A_MINSTRET, A_INSTRET:             csr_rdata_o = minstret_q;
      A_MVENDORID, A_MARCHID, A_MIMPID:  csr_rdata_o = '0;
      A_MHARTID:                         csr_rdata_o = XLEN'(HART_ID);
      default:                           hit = 1'b0;
    endcase
  end

  assign csr_rillegal_o = csr_rvalid_i && !hit;

  // The 11 encoding in waddr[11:10] marks read-only space, so those writes never decode.
  logic wr_en;
  assign wr_en = csr_wvalid_i && (csr_waddr_i[11:10] != 2'b11);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
      mie_q       <= '0;
      mip_q       <= '0;
      mtvec_q     <= '0;
      mscratch_q  <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      mcycle_q    <= '0;
      minstret_q  <= '0;
    end else begin
      mip_q <= {meip_i, mtip_i, msip_i};

      if (wr_en && csr_waddr_i == A_MCYCLE) mcycle_q <= csr_wdata_i;
      else                                  mcycle_q <= mcycle_q + XLEN'(1);

      if (wr_en && csr_waddr_i == A_MINSTRET) minstret_q <= csr_wdata_i;
      else                                    minstret_q <= minstret_q + XLEN'(retire_cnt_i);

      if (wr_en && csr_waddr_i == A_MIE)
        mie_q <= {csr_wdata_i[11], csr_wdata_i[7], csr_wdata_i[3]};
      if (wr_en && csr_waddr_i == A_MTVEC)
        mtvec_q <= {csr_wdata_i[XLEN-1:2], csr_wdata_i[1] ? 2'b00 : csr_wdata_i[1:0]};
      if (wr_en && csr_waddr_i == A_MSCRATCH)
        mscratch_q <= csr_wdata_i;

      // Trap beats mret beats CSR writes, but only on the registers the winner touches.
      if (trap_valid_i) begin
        mepc_q      <= {trap_pc_i[XLEN-1:1], 1'b0};
        mcause_q    <= trap_cause_i;
        mtval_q     <= trap_tval_i;
        status_mpie <= status_mie;
        status_mie  <= 1'b0;
      end else begin
        if (mret_i) begin
          status_mie  <= status_mpie;
          status_mpie <= 1'b1;
        end else if (wr_en && csr_waddr_i == A_MSTATUS) begin
          status_mie  <= csr_wdata_i[3];
          status_mpie <= csr_wdata_i[7];
        end
        if (wr_en && csr_waddr_i == A_MEPC)   mepc_q   <= {csr_wdata_i[XLEN-1:1], 1'b0};
        if (wr_en && csr_waddr_i == A_MCAUSE) mcause_q <= csr_wdata_i;
        if (wr_en && csr_waddr_i == A_MTVAL)  mtval_q  <= csr_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Bench for csr_regfile: reset read table, directed corner sequences, then random traffic
// checked against an address-indexed reference model of the CSR file.
module tb_csr_regfile;

  localparam int          XLEN    = 64;
  localparam int          HART_ID = 5;
  localparam logic [63:0] MISA    = 64'h8000_0000_0000_1101;

  logic        clk, rstn;
  logic        csr_rvalid_i, csr_wvalid_i, trap_valid_i, mret_i, msip_i, mtip_i, meip_i;
  logic [11:0] csr_raddr_i, csr_waddr_i;
  logic [63:0] csr_rdata_o, csr_wdata_i, trap_pc_i, trap_cause_i, trap_tval_i, mtvec_o, mepc_o;
  logic [1:0]  retire_cnt_i;
  logic        csr_rillegal_o, irq_pending_o;

  csr_regfile #(.XLEN(XLEN), .HART_ID(HART_ID)) dut (
    .clk(clk), .rstn(rstn),
    .csr_rvalid_i(csr_rvalid_i), .csr_raddr_i(csr_raddr_i), .csr_rdata_o(csr_rdata_o),
    .csr_rillegal_o(csr_rillegal_o),
    .csr_wvalid_i(csr_wvalid_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
    .retire_cnt_i(retire_cnt_i),
    .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i), .trap_cause_i(trap_cause_i),
    .trap_tval_i(trap_tval_i), .mret_i(mret_i),
    .msip_i(msip_i), .mtip_i(mtip_i), .meip_i(meip_i),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .irq_pending_o(irq_pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference state: one entry per stored CSR, holding the value a read returns.
  logic [63:0] mdl [int];

  typedef struct {
    logic [11:0] addr;
    logic        rvalid;
    logic [63:0] rdata;
    logic        illegal;
  } read_vec_t;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    mdl.delete();
    mdl[12'h300] = 64'h1800;
    mdl[12'h304] = 0; mdl[12'h305] = 0; mdl[12'h340] = 0; mdl[12'h341] = 0;
    mdl[12'h342] = 0; mdl[12'h343] = 0; mdl[12'h344] = 0;
    mdl[12'hB00] = 0; mdl[12'hB02] = 0;
  endfunction

  function automatic void model_read(input logic [11:0] a, input logic rv,
                                     output logic [63:0] d, output logic ill);
    d = 0;
    ill = 1'b0;
    case (a)
      12'h301:                   d = MISA;
      12'hF11, 12'hF12, 12'hF13: d = 0;
      12'hF14:                   d = 64'(HART_ID);
      12'hC00:                   d = mdl[12'hB00];
      12'hC02:                   d = mdl[12'hB02];
      default:
        if (mdl.exists(int'(a))) d = mdl[int'(a)];
        else                     ill = rv;
    endcase
  endfunction

  function automatic void model_step();
    logic [63:0] nxt [int];
    logic [63:0] w;
    logic [63:0] old_st;
    if (!rstn) begin
      model_reset();
      return;
    end
    nxt = mdl;
    w = csr_wdata_i;
    old_st = mdl[12'h300];
    nxt[12'hB00] = mdl[12'hB00] + 1;
    nxt[12'hB02] = mdl[12'hB02] + 64'(retire_cnt_i);
    nxt[12'h344] = (64'(meip_i) << 11) | (64'(mtip_i) << 7) | (64'(msip_i) << 3);
    if (csr_wvalid_i) begin
      case (csr_waddr_i)
        12'h300: if (!trap_valid_i && !mret_i) nxt[12'h300] = 64'h1800 | (w & 64'h88);
        12'h304: nxt[12'h304] = w & 64'h888;
        12'h305: nxt[12'h305] = w[1] ? (w & ~64'h3) : w;
        12'h340: nxt[12'h340] = w;
        12'h341: if (!trap_valid_i) nxt[12'h341] = w & ~64'h1;
        12'h342: if (!trap_valid_i) nxt[12'h342] = w;
        12'h343: if (!trap_valid_i) nxt[12'h343] = w;
        12'hB00: nxt[12'hB00] = w;
        12'hB02: nxt[12'hB02] = w;
        default: ;
      endcase
    end
    if (trap_valid_i) begin
      nxt[12'h341] = trap_pc_i & ~64'h1;
      nxt[12'h342] = trap_cause_i;
      nxt[12'h343] = trap_tval_i;
      nxt[12'h300] = 64'h1800 | (old_st[3] ? 64'h80 : 64'h0);
    end else if (mret_i) begin
      nxt[12'h300] = 64'h1880 | (old_st[7] ? 64'h8 : 64'h0);
    end
    mdl = nxt;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus();
    csr_rvalid_i = 0; csr_raddr_i = 0; csr_wvalid_i = 0; csr_waddr_i = 0; csr_wdata_i = 0;
    retire_cnt_i = 0; trap_valid_i = 0; trap_pc_i = 0; trap_cause_i = 0; trap_tval_i = 0;
    mret_i = 0; msip_i = 0; mtip_i = 0; meip_i = 0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
    csr_wvalid_i = 1; csr_waddr_i = a; csr_wdata_i = d;
    tick();
    csr_wvalid_i = 0;
  endtask

  task automatic read_check(input string name, input logic [11:0] a, input logic [63:0] exp);
    csr_raddr_i = a;
    #1;
    check_output(name, csr_rdata_o, exp);
  endtask

  task automatic check_all();
    logic [63:0] d;
    logic        ill;
    logic [63:0] st;
    model_read(csr_raddr_i, csr_rvalid_i, d, ill);
    st = mdl[12'h300];
    check_output("rdata", csr_rdata_o, d);
    check_output("rillegal", 64'(csr_rillegal_o), 64'(ill));
    check_output("mtvec_o", mtvec_o, mdl[12'h305]);
    check_output("mepc_o", mepc_o, mdl[12'h341]);
    check_output("irq_pending", 64'(irq_pending_o),
                 64'(((mdl[12'h344] & mdl[12'h304]) != 0) && st[3]));
  endtask

  logic [11:0] addr_list [18];
  read_vec_t   vecs [12];

  initial begin
    vecs[0]  = '{12'h300, 1'b1, 64'h1800, 1'b0};
    vecs[1]  = '{12'h301, 1'b1, MISA, 1'b0};
    vecs[2]  = '{12'hF14, 1'b1, 64'(HART_ID), 1'b0};
    vecs[3]  = '{12'hF11, 1'b1, 64'h0, 1'b0};
    vecs[4]  = '{12'hF13, 1'b1, 64'h0, 1'b0};
    vecs[5]  = '{12'h7C0, 1'b1, 64'h0, 1'b1};
    vecs[6]  = '{12'h7C0, 1'b0, 64'h0, 1'b0};
    vecs[7]  = '{12'h344, 1'b1, 64'h0, 1'b0};
    vecs[8]  = '{12'hC02, 1'b1, 64'h0, 1'b0};
    vecs[9]  = '{12'h305, 1'b1, 64'h0, 1'b0};
    vecs[10] = '{12'h123, 1'b1, 64'h0, 1'b1};
    vecs[11] = '{12'h340, 1'b1, 64'h0, 1'b0};
    addr_list = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                  12'h344, 12'hB00, 12'hB02, 12'hC00, 12'hC02, 12'hF11, 12'hF14, 12'h7C0,
                  12'hB01, 12'h306};

    apply_stimulus();
    rstn = 0;
    model_reset();
    tick();
    tick();
    rstn = 1;

    check_output("reset mtvec_o", mtvec_o, 64'h0);
    check_output("reset mepc_o", mepc_o, 64'h0);
    check_output("reset irq", 64'(irq_pending_o), 64'h0);
    for (int i = 0; i < 12; i++) begin
      csr_raddr_i  = vecs[i].addr;
      csr_rvalid_i = vecs[i].rvalid;
      #1;
      check_output($sformatf("reset read %h", vecs[i].addr), csr_rdata_o, vecs[i].rdata);
      check_output($sformatf("reset illegal %h", vecs[i].addr), 64'(csr_rillegal_o),
                   64'(vecs[i].illegal));
      tick();
    end
    csr_rvalid_i = 0;

    // Same-cycle write is not forwarded to the read port.
    csr_raddr_i = 12'h340; csr_wvalid_i = 1; csr_waddr_i = 12'h340; csr_wdata_i = 64'hDEAD;
    #1;
    check_output("mscratch no bypass", csr_rdata_o, 64'h0);
    tick();
    csr_wvalid_i = 0;
    read_check("mscratch next cycle", 12'h340, 64'hDEAD);

    csr_write(12'h305, 64'h8000_0003);
    read_check("mtvec warl", 12'h305, 64'h8000_0000);
    check_output("mtvec_o", mtvec_o, 64'h8000_0000);
    csr_write(12'h305, 64'h8000_0101);
    check_output("mtvec vectored", mtvec_o, 64'h8000_0101);
    csr_write(12'h300, '1);
    read_check("mstatus warl", 12'h300, 64'h1888);
    csr_write(12'h304, '1);
    read_check("mie warl", 12'h304, 64'h888);
    csr_write(12'h341, 64'h3333);
    check_output("mepc bit0", mepc_o, 64'h3332);
    csr_write(12'hC00, 64'h55);
    read_check("cycle alias ro", 12'h340, 64'hDEAD);
    csr_write(12'h300, 64'h0);

    csr_write(12'hB00, '1);
    read_check("mcycle written", 12'hB00, '1);
    tick();
    read_check("mcycle wrap", 12'hC00, 64'h0);
    retire_cnt_i = 3;
    csr_write(12'hB02, 64'h5);
    retire_cnt_i = 0;
    read_check("minstret write wins", 12'hB02, 64'h5);
    retire_cnt_i = 2;
    tick();
    retire_cnt_i = 0;
    read_check("minstret retire", 12'hC02, 64'h7);

    csr_write(12'h300, 64'h8);
    trap_valid_i = 1; trap_pc_i = 64'h1001; trap_cause_i = 64'h2; trap_tval_i = 64'h77;
    tick();
    trap_valid_i = 0;
    check_output("trap mepc", mepc_o, 64'h1000);
    read_check("trap mcause", 12'h342, 64'h2);
    read_check("trap mtval", 12'h343, 64'h77);
    read_check("trap mstatus", 12'h300, 64'h1880);
    mret_i = 1;
    tick();
    mret_i = 0;
    read_check("mret mstatus", 12'h300, 64'h1888);

    csr_write(12'h304, 64'h80);
    mtip_i = 1;
    #1;
    check_output("irq not yet", 64'(irq_pending_o), 64'h0);
    tick();
    check_output("irq pending", 64'(irq_pending_o), 64'h1);
    tick();
    check_output("irq held", 64'(irq_pending_o), 64'h1);
    trap_valid_i = 1; trap_pc_i = 64'h2000; trap_cause_i = 64'h8000_0000_0000_0007;
    csr_wvalid_i = 1; csr_waddr_i = 12'h341; csr_wdata_i = 64'h5550;
    tick();
    trap_valid_i = 0; csr_wvalid_i = 0; mtip_i = 0;
    check_output("trap beats mepc write", mepc_o, 64'h2000);
    check_output("irq masked by trap", 64'(irq_pending_o), 64'h0);

    csr_wvalid_i = 1; csr_waddr_i = 12'h340; csr_wdata_i = 64'h1234; trap_valid_i = 1;
    rstn = 0;
    tick();
    rstn = 1;
    apply_stimulus();
    read_check("reset over write", 12'h340, 64'h0);
    check_output("reset over trap", mepc_o, 64'h0);

    for (int n = 0; n < 400; n++) begin
      csr_rvalid_i = 1'($urandom);
      csr_raddr_i  = ($urandom_range(0, 3) != 0) ? addr_list[$urandom_range(0, 17)]
                                                 : 12'($urandom);
      csr_wvalid_i = 1'($urandom);
      csr_waddr_i  = addr_list[$urandom_range(0, 17)];
      csr_wdata_i  = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) csr_wdata_i = '1;
      retire_cnt_i = 2'($urandom);
      trap_valid_i = ($urandom_range(0, 15) == 0);
      mret_i       = ($urandom_range(0, 9) == 0);
      trap_pc_i    = {$urandom, $urandom};
      trap_cause_i = {$urandom, $urandom};
      trap_tval_i  = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) {meip_i, mtip_i, msip_i} = 3'($urandom);
      #1;
      check_all();
      tick();
    end
    apply_stimulus();
    #1;
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
